// File: rtl/spmv_merge_node.sv
// rtl/spmv_merge_node.sv - two-input id-sorted merge/reduce node for the SpMV partial-product tree
//
// Merges two id-sorted (id, val) streams into one id-sorted stream. In merge-add mode (MODE=0)
// beats with equal ids are summed into a single beat. In merge-only mode (MODE=1) equal ids are
// emitted A first, then B. The output goes through a registered 2-entry skid FIFO.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   a_id/a_val/a_valid/a_last     stream A beat; a_ready high when A is consumed this cycle
//   b_id/b_val/b_valid/b_last     stream B beat; b_ready high when B is consumed this cycle
//   o_id/o_val/o_valid/o_last     merged output beat (head of the skid FIFO)
//   o_ready                       downstream accepts the output beat
module spmv_merge_node #(
  parameter int IN_WIDTH = 32,
  parameter int ID_WIDTH = 32,
  parameter int MODE     = 0,
  parameter int SIGNED   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] a_id,
  input  logic [IN_WIDTH-1:0] a_val,
  input  logic                a_valid,
  input  logic                a_last,
  output logic                a_ready,
  input  logic [ID_WIDTH-1:0] b_id,
  input  logic [IN_WIDTH-1:0] b_val,
  input  logic                b_valid,
  input  logic                b_last,
  output logic                b_ready,
  output logic [ID_WIDTH-1:0] o_id,
  output logic [IN_WIDTH-1:0] o_val,
  output logic                o_valid,
  output logic                o_last,
  input  logic                o_ready
);

  logic [1:0]          cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] id0_q, id0_d, id1_q, id1_d;
  logic [IN_WIDTH-1:0] val0_q, val0_d, val1_q, val1_d;
  logic                last0_q, last0_d, last1_q, last1_d;
  logic                a_done_q, a_done_d, b_done_q, b_done_d;

  logic                slot, pop, push;
  logic                a_pres, b_pres, cons_a, cons_b, e_last;
  logic [ID_WIDTH-1:0] e_id;
  logic [IN_WIDTH-1:0] e_val, sum;

  // Both branches wrap modulo 2^IN_WIDTH; SIGNED only changes how the value is interpreted.
  generate
    if (SIGNED != 0) begin : g_sum_signed
      assign sum = $unsigned($signed(a_val) + $signed(b_val));
    end else begin : g_sum_unsigned
      assign sum = a_val + b_val;
    end
  endgenerate

  // slot comes from registered occupancy only, so o_ready never reaches a_ready/b_ready.
  assign slot   = (cnt_q != 2'd2);
  assign pop    = (cnt_q != 2'd0) && o_ready;
  assign a_pres = a_valid && !a_done_q;
  assign b_pres = b_valid && !b_done_q;

  always_comb begin
    cons_a = 1'b0;
    cons_b = 1'b0;
    e_id   = a_id;
    e_val  = a_val;
    if (slot && !rst) begin
      if (a_pres && b_pres) begin
        if ((a_id == b_id) && (MODE == 0)) begin
          cons_a = 1'b1;
          cons_b = 1'b1;
          e_val  = sum;
        end else if (a_id <= b_id) begin
          cons_a = 1'b1;
        end else begin
          cons_b = 1'b1;
          e_id   = b_id;
          e_val  = b_val;
        end
      end else if (a_pres && b_done_q) begin
        cons_a = 1'b1;
      end else if (b_pres && a_done_q) begin
        cons_b = 1'b1;
        e_id   = b_id;
        e_val  = b_val;
      end
    end
  end

  assign push    = cons_a || cons_b;
  assign a_ready = cons_a;
  assign b_ready = cons_b;

  // The emitted beat closes the merge when both streams are done after this cycle's consumption.
  assign e_last = (a_done_q || (cons_a && a_last)) && (b_done_q || (cons_b && b_last));

  always_comb begin
    a_done_d = a_done_q || (cons_a && a_last);
    b_done_d = b_done_q || (cons_b && b_last);
    if (push && e_last) begin
      a_done_d = 1'b0;
      b_done_d = 1'b0;
    end
  end

  // Shift-style skid FIFO: entry 0 is always the head presented on o_*.
  always_comb begin
    cnt_d   = cnt_q;
    id0_d   = id0_q;
    val0_d  = val0_q;
    last0_d = last0_q;
    id1_d   = id1_q;
    val1_d  = val1_q;
    last1_d = last1_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          id0_d   = e_id;
          val0_d  = e_val;
          last0_d = e_last;
          cnt_d   = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          id0_d   = e_id;
          val0_d  = e_val;
          last0_d = e_last;
        end else if (pop) begin
          cnt_d = 2'd0;
        end else if (push) begin
          id1_d   = e_id;
          val1_d  = e_val;
          last1_d = e_last;
          cnt_d   = 2'd2;
        end
      end
      2'd2: begin
        if (pop) begin
          id0_d   = id1_q;
          val0_d  = val1_q;
          last0_d = last1_q;
          cnt_d   = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      id0_q    <= '0;
      val0_q   <= '0;
      last0_q  <= 1'b0;
      id1_q    <= '0;
      val1_q   <= '0;
      last1_q  <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      id0_q    <= id0_d;
      val0_q   <= val0_d;
      last0_q  <= last0_d;
      id1_q    <= id1_d;
      val1_q   <= val1_d;
      last1_q  <= last1_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
    end
  end

  assign o_valid = (cnt_q != 2'd0);
  assign o_id    = id0_q;
  assign o_val   = val0_q;
  assign o_last  = last0_q;

endmodule
